// File: rtl/riscv_pkg.sv
// Shared RISC-V front-end constants and the fetch buffer entry payload.
package riscv_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned ILEN = 32;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] instr;
  } fetch_entry_t;

  // Sequential word address, wrapping naturally at 2^XLEN.
  function automatic logic [XLEN-1:0] pc_next(input logic [XLEN-1:0] pc);
    return pc + XLEN'(4);
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// In-order instruction buffer: DEPTH entries of {pc, instr}, same-cycle push/pop, flush.
module fetch_fifo
  import riscv_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 i_push,
  input  fetch_entry_t                         i_entry,
  input  logic                                 i_pop,
  input  logic                                 i_flush,
  output logic                                 o_valid,
  output fetch_entry_t                         o_head,
  output logic [$clog2(DEPTH+1)-1:0]           o_count
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  fetch_entry_t   r_mem [DEPTH];
  logic [PW-1:0]  r_rd;
  logic [PW-1:0]  r_wr;
  logic [CW-1:0]  r_count;
  logic           w_push;
  logic           w_pop;

  // Pointers wrap explicitly so non-power-of-two depths work.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign w_push  = i_push && !i_flush;
  assign w_pop   = i_pop && !i_flush && (r_count != '0);
  assign o_valid = (r_count != '0);
  assign o_head  = o_valid ? r_mem[r_rd] : '0;
  assign o_count = r_count;

  always_ff @(posedge clk) begin
    if (rst || i_flush) begin
      r_rd    <= '0;
      r_wr    <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wr <= ptr_inc(r_wr);
      if (w_pop)  r_rd <= ptr_inc(r_rd);
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr] <= i_entry;
  end

  // Upstream credit accounting must never let a push land on a full buffer.
  always_ff @(posedge clk) begin
    if (!rst && w_push) begin
      assert (r_count < CW'(DEPTH))
        else $error("fetch_fifo: push into full buffer");
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: credit-limited requests to imem, in-order response buffering,
// redirect with stale-response discard.
module fetch_unit
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int unsigned     DEPTH    = 2
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_req_ready,
  input  logic            imem_rsp_valid,
  input  logic [ILEN-1:0] imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            if_valid,
  output logic [ILEN-1:0] if_instr,
  output logic [XLEN-1:0] if_pc,
  input  logic            id_ready
);

  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [XLEN-1:0] r_fetch_pc;
  logic [XLEN-1:0] r_rsp_pc;
  logic [CW-1:0]   r_outstanding;
  logic [CW-1:0]   r_discard;

  logic [CW-1:0]   w_buf_count;
  logic            w_credit;
  logic            w_accept;
  logic            w_rsp;
  logic            w_keep;
  logic            w_pop;
  logic [XLEN-1:0] w_redirect_pc;
  fetch_entry_t    w_push_entry;
  fetch_entry_t    w_head;

  // Requests in flight plus buffered instructions may never exceed DEPTH.
  assign w_credit = ((CW+1)'(r_outstanding) + (CW+1)'(w_buf_count)) < (CW+1)'(DEPTH);

  assign imem_req_valid = !rst && !redirect_valid && w_credit;
  assign imem_req_addr  = r_fetch_pc;
  assign w_accept       = imem_req_valid && imem_req_ready;
  assign w_rsp          = imem_rsp_valid && !rst;
  assign w_keep         = w_rsp && !redirect_valid && (r_discard == '0);
  assign w_pop          = if_valid && id_ready && !redirect_valid;
  assign w_redirect_pc  = {redirect_pc[XLEN-1:2], 2'b00};
  assign w_push_entry   = '{pc: r_rsp_pc, instr: imem_rsp_data};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fetch_pc    <= RESET_PC;
      r_rsp_pc      <= RESET_PC;
      r_outstanding <= '0;
      r_discard     <= '0;
    end else begin
      r_outstanding <= r_outstanding + CW'(w_accept) - CW'(w_rsp);
      if (redirect_valid) begin
        r_fetch_pc <= w_redirect_pc;
        r_rsp_pc   <= w_redirect_pc;
        // Everything still in flight belongs to the abandoned stream.
        if (w_rsp && (r_outstanding != '0)) r_discard <= r_outstanding - CW'(1);
        else                                r_discard <= r_outstanding;
      end else begin
        if (w_accept) r_fetch_pc <= pc_next(r_fetch_pc);
        if (w_keep)   r_rsp_pc   <= pc_next(r_rsp_pc);
        else if (w_rsp && (r_discard != '0)) r_discard <= r_discard - CW'(1);
      end
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_keep),
    .i_entry (w_push_entry),
    .i_pop   (w_pop),
    .i_flush (redirect_valid),
    .o_valid (if_valid),
    .o_head  (w_head),
    .o_count (w_buf_count)
  );

  assign if_instr = w_head.instr;
  assign if_pc    = w_head.pc;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: variable-latency memory model plus an epoch-tagged reference queue.
module tb_fetch_unit;
  import riscv_pkg::*;

  localparam int unsigned DEPTH    = 3;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        id_ready;

  always #5 clk = ~clk;

  fetch_unit #(
    .RESET_PC (RESET_PC),
    .DEPTH    (DEPTH)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_addr  (imem_req_addr),
    .imem_req_ready (imem_req_ready),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .if_valid       (if_valid),
    .if_instr       (if_instr),
    .if_pc          (if_pc),
    .id_ready       (id_ready)
  );

  typedef struct {
    logic [31:0] addr;
    int unsigned epoch;
    int unsigned due;
  } mreq_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  mreq_t       mem_q[$];
  ent_t        buf_q[$];
  int unsigned epoch = 0;
  int unsigned cyc = 0;
  int unsigned last_due = 0;
  logic [31:0] next_fetch = RESET_PC;
  int          vectors = 0;
  int          errors = 0;
  bit          init_done = 1'b0;
  bit          after_reset = 1'b0;

  logic        t_rst, t_redir, t_ready, t_idr;
  logic [31:0] t_rpc;
  int unsigned lat;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
      else begin
        errors++;
        $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
  endtask

  // One clock cycle: drive, check mid-cycle, then advance the reference model.
  task automatic step();
    logic        rv, exp_req, accept, pop;
    logic [31:0] rd;
    int unsigned due;
    mreq_t       m;
    rv = 1'b0;
    rd = $urandom;
    if (t_rst) rv = 1'($urandom_range(0, 1));
    else if (mem_q.size() != 0 && mem_q[0].due <= cyc) begin
      rv = 1'b1;
      rd = mem_word(mem_q[0].addr);
    end
    rst = t_rst; redirect_valid = t_redir; redirect_pc = t_rpc;
    imem_req_ready = t_ready; id_ready = t_idr;
    imem_rsp_valid = rv; imem_rsp_data = rd;
    #4;
    exp_req = !t_rst && !t_redir && ((mem_q.size() + buf_q.size()) < DEPTH);
    if (init_done) begin
      check("req_valid", 32'(imem_req_valid), 32'(exp_req));
      if (exp_req) check("req_addr", imem_req_addr, next_fetch);
      check("if_valid", 32'(if_valid), 32'(buf_q.size() != 0));
      if (buf_q.size() != 0) begin
        check("if_pc", if_pc, buf_q[0].pc);
        check("if_instr", if_instr, buf_q[0].instr);
      end else if (after_reset) begin
        check("if_pc_rst", if_pc, 32'h0);
        check("if_instr_rst", if_instr, 32'h0);
      end
    end
    accept = exp_req && t_ready;
    pop    = !t_rst && !t_redir && t_idr && (buf_q.size() != 0);
    @(posedge clk);
    if (t_rst) begin
      mem_q.delete();
      buf_q.delete();
      epoch++;
      next_fetch  = RESET_PC;
      init_done   = 1'b1;
      after_reset = 1'b1;
    end else begin
      after_reset = 1'b0;
      if (pop) void'(buf_q.pop_front());
      if (rv) begin
        m = mem_q.pop_front();
        if (!t_redir && m.epoch == epoch) buf_q.push_back('{m.addr, mem_word(m.addr)});
      end
      if (t_redir) begin
        buf_q.delete();
        epoch++;
        next_fetch = {t_rpc[31:2], 2'b00};
      end else if (accept) begin
        due = (cyc + lat > last_due + 1) ? cyc + lat : last_due + 1;
        mem_q.push_back('{next_fetch, epoch, due});
        last_due   = due;
        next_fetch = next_fetch + 32'd4;
      end
    end
    cyc++;
    #1;
  endtask

  initial begin
    t_rst = 1'b1; t_redir = 1'b0; t_rpc = 32'h0; t_ready = 1'b0; t_idr = 1'b0; lat = 1;
    repeat (2) step();

    // Streaming with single-cycle memory and an always-ready decoder.
    t_rst = 1'b0; t_ready = 1'b1; t_idr = 1'b1;
    repeat (20) step();

    // Decode stall fills the buffer, then drains in order.
    t_idr = 1'b0;
    repeat (10) step();
    t_idr = 1'b1;
    repeat (10) step();

    // Slow memory, redirect to an unaligned target with requests in flight.
    lat = 3;
    repeat (6) step();
    t_redir = 1'b1; t_rpc = 32'h0000_0103;
    step();
    t_redir = 1'b0;
    repeat (12) step();

    // Redirect while a response and a pop coincide, then back-to-back redirects.
    lat = 1;
    repeat (6) step();
    t_redir = 1'b1; t_rpc = 32'h0000_0200;
    step();
    t_rpc = 32'h0000_0300;
    step();
    t_rpc = 32'h0000_0400;
    step();
    t_redir = 1'b0;
    repeat (8) step();

    // Address wrap past the top of memory.
    t_redir = 1'b1; t_rpc = 32'hFFFF_FFF8;
    step();
    t_redir = 1'b0;
    repeat (10) step();

    // Reset with a full buffer and requests in flight.
    t_idr = 1'b0; lat = 3;
    repeat (8) step();
    t_rst = 1'b1;
    step();
    t_rst = 1'b0; t_idr = 1'b1;
    repeat (10) step();

    // Randomized traffic.
    repeat (1500) begin
      t_rst   = ($urandom_range(0, 99) == 0);
      t_redir = ($urandom_range(0, 19) == 0);
      t_rpc   = $urandom;
      if ($urandom_range(0, 3) == 0) t_rpc = 32'hFFFF_FFF0 | ($urandom & 32'hF);
      t_ready = ($urandom_range(0, 3) != 0);
      t_idr   = ($urandom_range(0, 3) != 0);
      lat     = $urandom_range(1, 4);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
